// File: rtl/sgf_round_norm.sv
// ============================================================================
// Module   : sgf_round_norm
// Brief    : Two-stage normalize/round of a 2*SW-bit significand product in [1,4)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module sgf_round_norm #(
    parameter int SW = 24
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [2*SW-1:0] sgf_result_i,
    input  logic            sign_i,
    input  logic [1:0]      rmode_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [SW-1:0]   sgf_o,
    output logic [1:0]      exp_adj_o,
    output logic            inexact_o,
    output logic            zero_o
);

    localparam logic [1:0] c_RM_RNE  = 2'b00;
    localparam logic [1:0] c_RM_RTZ  = 2'b01;
    localparam logic [1:0] c_RM_PINF = 2'b10;
    localparam logic [1:0] c_RM_NINF = 2'b11;

    // Stage 1 state
    logic          r_v1;
    logic [SW-1:0] r_m1;
    logic          r_n1;
    logic          r_g1;
    logic          r_s1;
    logic          r_l1;
    logic          r_sign1;
    logic [1:0]    r_rmode1;
    logic          r_z1;

    // Stage 2 (output) state
    logic          r_v2;
    logic [SW-1:0] r_sgf2;
    logic [1:0]    r_adj2;
    logic          r_inx2;
    logic          r_zero2;

    logic          w_adv2;
    logic          w_ready;
    logic          w_n;
    logic [SW-1:0] w_m;
    logic          w_g;
    logic          w_s;
    logic          w_z;
    logic          w_inc;
    logic [SW:0]   w_r;
    logic [SW-1:0] w_sgf;
    logic [1:0]    w_adj;
    logic          w_inx;

    assign w_adv2  = ~r_v2 | ready_i;
    assign w_ready = ~r_v1 | w_adv2;
    assign ready_o = w_ready;
    assign valid_o = r_v2;

    // Only a single-bit normalization: products below 1.0 are taken as-is.
    always_comb begin
        w_n = sgf_result_i[2*SW-1];
        w_z = (sgf_result_i == '0);
        if (w_n) begin
            w_m = sgf_result_i[2*SW-1:SW];
            w_g = sgf_result_i[SW-1];
            w_s = |sgf_result_i[SW-2:0];
        end else begin
            w_m = sgf_result_i[2*SW-2:SW-1];
            w_g = sgf_result_i[SW-2];
            w_s = |sgf_result_i[SW-3:0];
        end
    end

    always_comb begin
        w_inc = 1'b0;
        case (r_rmode1)
            c_RM_RNE:  w_inc = r_g1 & (r_l1 | r_s1);
            c_RM_RTZ:  w_inc = 1'b0;
            c_RM_PINF: w_inc = (r_g1 | r_s1) & ~r_sign1;
            c_RM_NINF: w_inc = (r_g1 | r_s1) & r_sign1;
            default:   w_inc = 1'b0;
        endcase
        w_r   = {1'b0, r_m1} + {{SW{1'b0}}, w_inc};
        w_inx = r_g1 | r_s1;
        if (r_z1) begin
            w_sgf = '0;
            w_adj = 2'd0;
            w_inx = 1'b0;
        end else if (w_r[SW]) begin
            // Carry-out leaves exactly 10.00..0; renormalize by one.
            w_sgf = {1'b1, {(SW-1){1'b0}}};
            w_adj = {1'b0, r_n1} + 2'd1;
        end else begin
            w_sgf = w_r[SW-1:0];
            w_adj = {1'b0, r_n1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v1     <= 1'b0;
            r_m1     <= '0;
            r_n1     <= 1'b0;
            r_g1     <= 1'b0;
            r_s1     <= 1'b0;
            r_l1     <= 1'b0;
            r_sign1  <= 1'b0;
            r_rmode1 <= 2'b00;
            r_z1     <= 1'b0;
        end else if (w_ready) begin
            r_v1 <= valid_i;
            if (valid_i) begin
                r_m1     <= w_m;
                r_n1     <= w_n;
                r_g1     <= w_g;
                r_s1     <= w_s;
                r_l1     <= w_m[0];
                r_sign1  <= sign_i;
                r_rmode1 <= rmode_i;
                r_z1     <= w_z;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_v2    <= 1'b0;
            r_sgf2  <= '0;
            r_adj2  <= 2'd0;
            r_inx2  <= 1'b0;
            r_zero2 <= 1'b0;
        end else if (w_adv2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_sgf2  <= w_sgf;
                r_adj2  <= w_adj;
                r_inx2  <= w_inx;
                r_zero2 <= r_z1;
            end
        end
    end

    assign sgf_o     = r_sgf2;
    assign exp_adj_o = r_adj2;
    assign inexact_o = r_inx2;
    assign zero_o    = r_zero2;

endmodule

`default_nettype wire

// File: tb/tb_sgf_round_norm.sv
// ============================================================================
// Module   : tb_sgf_round_norm
// Brief    : Directed self-checking bench for sgf_round_norm (SW=24)
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_sgf_round_norm;

    localparam int SW = 24;
    localparam int W  = 2 * SW;

    logic          clk;
    logic          rst;
    logic          valid_i;
    logic          ready_o;
    logic [W-1:0]  sgf_result_i;
    logic          sign_i;
    logic [1:0]    rmode_i;
    logic          valid_o;
    logic          ready_i;
    logic [SW-1:0] sgf_o;
    logic [1:0]    exp_adj_o;
    logic          inexact_o;
    logic          zero_o;

    int errors = 0;
    int checks = 0;
    int cyc    = 0;

    logic [SW-1:0] mon_q[$];
    int            mon_cyc[$];

    sgf_round_norm #(.SW(SW)) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .sgf_result_i (sgf_result_i),
        .sign_i       (sign_i),
        .rmode_i      (rmode_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .sgf_o        (sgf_o),
        .exp_adj_o    (exp_adj_o),
        .inexact_o    (inexact_o),
        .zero_o       (zero_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    // Output transfers observed mid-cycle, committed at the following edge.
    always @(negedge clk) begin
        if (!rst && valid_o && ready_i) begin
            mon_q.push_back(sgf_o);
            mon_cyc.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Hold a product on the input until accepted; returns 1ns after the accepting edge.
    task automatic push(input logic [W-1:0] p, input logic s, input logic [1:0] m);
        bit ok;
        ok           = 1'b0;
        valid_i      = 1'b1;
        sgf_result_i = p;
        sign_i       = s;
        rmode_i      = m;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (ready_o) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        valid_i = 1'b0;
        if (!ok) check("push_timeout", 64'd0, 64'd1);
    endtask

    task automatic run1(input string tag, input logic [W-1:0] p, input logic s,
                        input logic [1:0] m, input logic [SW-1:0] e_sgf,
                        input logic [1:0] e_adj, input logic e_inx, input logic e_zero);
        push(p, s, m);
        @(posedge clk);
        #1;
        check({tag, "_valid"}, 64'(valid_o), 64'd1);
        check({tag, "_sgf"}, 64'(sgf_o), 64'(e_sgf));
        check({tag, "_adj"}, 64'(exp_adj_o), 64'(e_adj));
        check({tag, "_inx"}, 64'(inexact_o), 64'(e_inx));
        check({tag, "_zero"}, 64'(zero_o), 64'(e_zero));
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst          = 1'b1;
        valid_i      = 1'b0;
        sgf_result_i = '0;
        sign_i       = 1'b0;
        rmode_i      = 2'b00;
        ready_i      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst_valid", 64'(valid_o), 64'd0);
        check("rst_sgf", 64'(sgf_o), 64'd0);
        check("rst_adj", 64'(exp_adj_o), 64'd0);
        check("rst_inx", 64'(inexact_o), 64'd0);
        check("rst_zero", 64'(zero_o), 64'd0);
        check("rst_ready", 64'(ready_o), 64'd1);

        // Directed vectors (hand-computed for SW=24)
        run1("exact",     48'h4000_0000_0000, 1'b0, 2'b00, 24'h800000, 2'd0, 1'b0, 1'b0);
        run1("shift",     48'h9000_0000_0000, 1'b0, 2'b00, 24'h900000, 2'd1, 1'b0, 1'b0);
        run1("tie_even",  48'h4000_0040_0000, 1'b0, 2'b00, 24'h800000, 2'd0, 1'b1, 1'b0);
        run1("tie_odd",   48'h4000_00C0_0000, 1'b0, 2'b00, 24'h800002, 2'd0, 1'b1, 1'b0);
        run1("co_rne",    48'h7FFF_FFC0_0000, 1'b0, 2'b00, 24'h800000, 2'd1, 1'b1, 1'b0);
        run1("co_rtz",    48'h7FFF_FFC0_0000, 1'b0, 2'b01, 24'hFFFFFF, 2'd0, 1'b1, 1'b0);
        run1("co_ninf_p", 48'h7FFF_FFC0_0000, 1'b0, 2'b11, 24'hFFFFFF, 2'd0, 1'b1, 1'b0);
        run1("co_pinf_p", 48'h7FFF_FFC0_0000, 1'b0, 2'b10, 24'h800000, 2'd1, 1'b1, 1'b0);
        run1("co_ninf_n", 48'h7FFF_FFC0_0000, 1'b1, 2'b11, 24'h800000, 2'd1, 1'b1, 1'b0);
        run1("co_pinf_n", 48'h7FFF_FFC0_0000, 1'b1, 2'b10, 24'hFFFFFF, 2'd0, 1'b1, 1'b0);
        run1("co_n1",     48'hFFFF_FF80_0000, 1'b0, 2'b00, 24'h800000, 2'd2, 1'b1, 1'b0);
        run1("sticky_rne",48'h4000_0000_0001, 1'b0, 2'b00, 24'h800000, 2'd0, 1'b1, 1'b0);
        run1("sticky_pinf",48'h4000_0000_0001,1'b0, 2'b10, 24'h800001, 2'd0, 1'b1, 1'b0);
        run1("zero",      48'h0000_0000_0000, 1'b0, 2'b10, 24'h000000, 2'd0, 1'b0, 1'b1);

        // Backpressure: two accepts fill the pipe, then ready_o must drop
        mon_q.delete();
        mon_cyc.delete();
        ready_i = 1'b0;
        push(48'h4000_0000_0000, 1'b0, 2'b00);
        push(48'h9000_0000_0000, 1'b0, 2'b00);
        valid_i      = 1'b1;
        sgf_result_i = 48'h4000_00C0_0000;
        rmode_i      = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_ready_low", 64'(ready_o), 64'd0);
            check("bp_valid", 64'(valid_o), 64'd1);
            check("bp_stable", 64'(sgf_o), 64'h800000);
            check("bp_adj_stable", 64'(exp_adj_o), 64'd0);
        end
        @(posedge clk);
        #1;
        ready_i = 1'b1;
        push(48'h4000_00C0_0000, 1'b0, 2'b00);
        push(48'h7FFF_FFC0_0000, 1'b0, 2'b01);
        repeat (5) @(posedge clk);
        #1;
        check("bp_count", 64'(mon_q.size()), 64'd4);
        if (mon_q.size() == 4) begin
            check("bp_r0", 64'(mon_q[0]), 64'h800000);
            check("bp_r1", 64'(mon_q[1]), 64'h900000);
            check("bp_r2", 64'(mon_q[2]), 64'h800002);
            check("bp_r3", 64'(mon_q[3]), 64'hFFFFFF);
            for (int k = 1; k < 4; k++)
                check("bp_consecutive", 64'(mon_cyc[k] - mon_cyc[k-1]), 64'd1);
        end

        // Reset with two products in flight
        push(48'h9000_0000_0000, 1'b0, 2'b00);
        ready_i = 1'b0;
        push(48'h4000_0000_0000, 1'b0, 2'b00);
        mon_q.delete();
        mon_cyc.delete();
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst     = 1'b0;
        ready_i = 1'b1;
        check("mid_rst_valid", 64'(valid_o), 64'd0);
        check("mid_rst_ready", 64'(ready_o), 64'd1);
        push(48'h7FFF_FFC0_0000, 1'b0, 2'b01);
        check("mid_rst_lat1", 64'(valid_o), 64'd0);
        @(posedge clk);
        #1;
        check("mid_rst_lat2", 64'(valid_o), 64'd1);
        repeat (4) @(posedge clk);
        #1;
        check("mid_rst_count", 64'(mon_q.size()), 64'd1);
        if (mon_q.size() == 1)
            check("mid_rst_val", 64'(mon_q[0]), 64'hFFFFFF);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
